// File: rtl/data_check_pkg.sv
// Shared widths, FSM encoding and default burst size for the counter-stream checker.
package data_check_pkg;

    localparam int DATA_W        = 32;
    localparam int CNT_W         = 16;
    localparam int DEF_BURST_LEN = 8192;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones. A clear together with an increment loads 1,
// which lets the checker restart its word count on the first word of a burst.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Count events, restarting on clear and holding once every bit is set.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_count <= '0;
        end else if (clr_in) begin
            r_count <= inc_in ? ONE : '0;
        end else if (inc_in && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign count_out = r_count;

endmodule

// File: rtl/data_checker.sv
// Sink for incrementing-counter bursts: checks each word against its predecessor + 1,
// measures burst length and reports per-burst status plus the first mismatch seen.
module data_checker
    import data_check_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              clear_in,
    output logic              locked_out,
    output logic              burst_done_out,
    output logic              burst_ok_out,
    output logic [CNT_W-1:0]  burst_len_out,
    output logic [CNT_W-1:0]  burst_cnt_out,
    output logic [CNT_W-1:0]  err_cnt_out,
    output logic [DATA_W-1:0] first_err_exp_out,
    output logic [DATA_W-1:0] first_err_got_out
);

    localparam logic [CNT_W-1:0]  LEN_TARGET = CNT_W'(BURST_LEN);
    localparam logic [DATA_W-1:0] DATA_ONE   = DATA_W'(1);

    state_t             r_state;
    logic [DATA_W-1:0]  r_expected;
    logic               r_locked;
    logic               r_burst_bad;
    logic               r_first_seen;
    logic               r_done;
    logic               r_ok;
    logic [CNT_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_first_exp;
    logic [DATA_W-1:0]  r_first_got;

    logic               w_check;
    logic               w_mismatch;
    logic               w_end;
    logic               w_word_clr;
    logic               w_word_inc;
    logic [CNT_W-1:0]   w_word_cnt;

    // The seed word is never checked; clear overrides everything presented with it.
    assign w_check    = valid_in && !clear_in && (r_state != UNLOCKED);
    assign w_mismatch = w_check && (data_in != r_expected);
    assign w_end      = !valid_in && !clear_in && (r_state == RUN);
    assign w_word_inc = valid_in && !clear_in;
    assign w_word_clr = clear_in || (valid_in && (r_state != RUN));

    sat_counter #(.WIDTH(CNT_W)) u_word_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (w_word_clr),
        .inc_in    (w_word_inc),
        .count_out (w_word_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (clear_in),
        .inc_in    (w_mismatch),
        .count_out (err_cnt_out)
    );

    sat_counter #(.WIDTH(CNT_W)) u_burst_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (clear_in),
        .inc_in    (w_end),
        .count_out (burst_cnt_out)
    );

    // Lock/idle/run sequencing with expected-value tracking and registered burst results.
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear_in) begin
            r_state      <= UNLOCKED;
            r_expected   <= '0;
            r_locked     <= 1'b0;
            r_burst_bad  <= 1'b0;
            r_first_seen <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
            r_len        <= '0;
            r_first_exp  <= '0;
            r_first_got  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                UNLOCKED: begin
                    if (valid_in) begin
                        r_expected <= data_in + DATA_ONE;
                        r_locked   <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                IDLE: begin
                    if (valid_in) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!valid_in) begin
                        r_done      <= 1'b1;
                        r_ok        <= (w_word_cnt == LEN_TARGET) && !r_burst_bad;
                        r_len       <= w_word_cnt;
                        r_burst_bad <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= UNLOCKED;
                end
            endcase

            if (w_check) begin
                r_expected <= data_in + DATA_ONE;
                if (w_mismatch) begin
                    r_burst_bad <= 1'b1;
                    if (!r_first_seen) begin
                        r_first_seen <= 1'b1;
                        r_first_exp  <= r_expected;
                        r_first_got  <= data_in;
                    end
                end
            end
        end
    end

    assign locked_out        = r_locked;
    assign burst_done_out    = r_done;
    assign burst_ok_out      = r_ok;
    assign burst_len_out     = r_len;
    assign first_err_exp_out = r_first_exp;
    assign first_err_got_out = r_first_got;

endmodule

// File: tb/tb_data_checker.sv
// Randomised scoreboard bench for data_checker: a behavioural stream model predicts
// each burst result, and a monitor compares whenever the DUT pulses burst_done_out.
module tb_data_checker;

    import data_check_pkg::*;

    localparam int BL = 8192;

    typedef struct {
        logic        ok;
        logic [15:0] len;
        logic [15:0] cnt;
        logic [15:0] err;
        logic [31:0] fexp;
        logic [31:0] fgot;
    } burst_exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        clear_in = 1'b0;
    logic        locked_out;
    logic        burst_done_out;
    logic        burst_ok_out;
    logic [15:0] burst_len_out;
    logic [15:0] burst_cnt_out;
    logic [15:0] err_cnt_out;
    logic [31:0] first_err_exp_out;
    logic [31:0] first_err_got_out;

    int checks = 0;
    int failures = 0;
    bit monOn = 1'b0;

    burst_exp_t sbQ[$];

    bit          mLocked;
    bit [31:0]   mExp;
    int          mRun;
    bit          mBad;
    int          mErr;
    int          mBursts;
    bit          mFirst;
    bit [31:0]   mFexp;
    bit [31:0]   mFgot;

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    data_checker #(.BURST_LEN(BL)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .data_in           (data_in),
        .valid_in          (valid_in),
        .clear_in          (clear_in),
        .locked_out        (locked_out),
        .burst_done_out    (burst_done_out),
        .burst_ok_out      (burst_ok_out),
        .burst_len_out     (burst_len_out),
        .burst_cnt_out     (burst_cnt_out),
        .err_cnt_out       (err_cnt_out),
        .first_err_exp_out (first_err_exp_out),
        .first_err_got_out (first_err_got_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mLocked = 0; mExp = '0; mRun = 0; mBad = 0; mErr = 0;
        mBursts = 0; mFirst = 0; mFexp = '0; mFgot = '0;
    endtask

    // Drive one cycle, then advance the stream model by what the DUT sampled.
    task automatic applyStimulus(input bit v, input bit [31:0] d, input bit clr, input bit rstn);
        burst_exp_t e;
        valid_in = v; data_in = d; clear_in = clr; rst_in = rstn;
        @(posedge clk_in);
        #1;
        if (!rstn || clr) begin
            modelReset();
        end else if (v) begin
            if (!mLocked) begin
                mLocked = 1;
                mRun = 1;
            end else begin
                if (d != mExp) begin
                    if (mErr < 65535) mErr++;
                    mBad = 1;
                    if (!mFirst) begin
                        mFirst = 1; mFexp = mExp; mFgot = d;
                    end
                end
                mRun = (mRun == 0) ? 1 : ((mRun < 65535) ? mRun + 1 : 65535);
            end
            mExp = d + 32'd1;
        end else if (mRun > 0) begin
            if (mBursts < 65535) mBursts++;
            e.ok   = (mRun == BL) && !mBad;
            e.len  = 16'(mRun);
            e.cnt  = 16'(mBursts);
            e.err  = 16'(mErr);
            e.fexp = mFexp;
            e.fgot = mFgot;
            sbQ.push_back(e);
            mRun = 0;
            mBad = 0;
        end
    endtask

    task automatic sendWords(input bit [31:0] start, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, start + 32'(i), 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 0, 1);
    endtask

    // Monitor: track lock/error state every cycle and score each burst completion.
    always @(negedge clk_in) begin
        burst_exp_t e;
        if (monOn) begin
            checkOutput("locked", 32'(locked_out), 32'(mLocked));
            checkOutput("err_cnt", 32'(err_cnt_out), 32'(mErr));
            if (burst_done_out === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done actual=1 required=0 at %0t", $time);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_ok", 32'(burst_ok_out), 32'(e.ok));
                    checkOutput("sb_len", 32'(burst_len_out), 32'(e.len));
                    checkOutput("sb_cnt", 32'(burst_cnt_out), 32'(e.cnt));
                    checkOutput("sb_err", 32'(err_cnt_out), 32'(e.err));
                    checkOutput("sb_fexp", first_err_exp_out, e.fexp);
                    checkOutput("sb_fgot", first_err_got_out, e.fgot);
                end
            end
        end
    end

    // Directed scenarios followed by randomised bursts with faults, clears and a reset.
    initial begin
        bit [31:0] cur;
        int        n;
        int        r;
        modelReset();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        monOn = 1'b1;
        checkOutput("reset_zero", 32'(|{locked_out, burst_done_out, burst_ok_out, burst_len_out,
                    burst_cnt_out, err_cnt_out, first_err_exp_out, first_err_got_out}), 32'h0);

        applyStimulus(1, 32'h0, 0, 1);
        checkOutput("locked_after_seed", 32'(locked_out), 32'h1);
        sendWords(32'h1, BL - 1);
        idle(1);
        checkOutput("b1_ok", 32'(burst_ok_out), 32'h1);
        checkOutput("b1_len", 32'(burst_len_out), 32'(BL));
        sendWords(32'h2000, BL);
        idle(2);
        checkOutput("b2_cnt", 32'(burst_cnt_out), 32'h2);
        checkOutput("b2_ok", 32'(burst_ok_out), 32'h1);

        applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < BL; i++)
            applyStimulus(1, (i == 16) ? 32'hDEADBEEF : 32'(i), 0, 1);
        idle(1);
        checkOutput("corrupt_err", 32'(err_cnt_out), 32'h2);
        checkOutput("corrupt_fexp", first_err_exp_out, 32'h10);
        checkOutput("corrupt_fgot", first_err_got_out, 32'hDEADBEEF);
        checkOutput("corrupt_ok", 32'(burst_ok_out), 32'h0);

        applyStimulus(0, 0, 1, 1);
        sendWords(32'hFFFFFFFE, BL);
        idle(1);
        checkOutput("wrap_err", 32'(err_cnt_out), 32'h0);
        checkOutput("wrap_ok", 32'(burst_ok_out), 32'h1);

        sendWords(32'h1FFE, 100);
        idle(1);
        checkOutput("short_len", 32'(burst_len_out), 32'd100);
        checkOutput("short_ok", 32'(burst_ok_out), 32'h0);
        checkOutput("short_err", 32'(err_cnt_out), 32'h0);

        sendWords(32'h2062, 50);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 32'h2094 + 32'(i), 1, 1);
            checkOutput("clear_zero", 32'(|{locked_out, burst_done_out, burst_ok_out, burst_len_out,
                        burst_cnt_out, err_cnt_out, first_err_exp_out, first_err_got_out}), 32'h0);
        end
        applyStimulus(1, 32'h12345678, 0, 1);
        checkOutput("reseed_locked", 32'(locked_out), 32'h1);
        sendWords(32'h12345679, 20);
        idle(1);
        checkOutput("reseed_err", 32'(err_cnt_out), 32'h0);
        checkOutput("reseed_len", 32'(burst_len_out), 32'd21);

        cur = $urandom;
        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(1, 60);
            for (int w = 0; w < n; w++) begin
                r = $urandom_range(0, 31);
                if (b == 12 && w == n / 2) begin
                    applyStimulus(1, cur, 0, 0);
                end else if (r == 0) begin
                    applyStimulus(1, $urandom, 0, 1);
                end else begin
                    if (r == 1) cur = cur + 32'd1;
                    applyStimulus(1, cur, 0, 1);
                end
                cur = cur + 32'd1;
            end
            if ($urandom_range(0, 9) == 0) applyStimulus(0, 0, 1, 1);
            idle($urandom_range(1, 3));
        end

        idle(3);
        checkOutput("sb_empty", 32'(sbQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_checker.md
# data_checker

Stream sink that consumes the 32-bit incrementing-counter bursts produced by the test data generator. It checks every valid word against the expected successor (value + 1, wrapping 0xFFFFFFFF→0x00000000), measures each burst's length against the nominal burst size, and reports per-burst pass/fail, a saturating error count and the first mismatch seen. It sits at the far end of the FIFO path under test, in the same clock domain as the FIFO read side.

## Interface
- BURST_LEN, 8192: nominal words per burst; must be ≤ 65535.
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous reset, active-low (0 = reset).
- data_in  input  32  stream data; sampled only when valid_in = 1.
- valid_in  input  1  word qualifier; a burst is a maximal run of consecutive valid_in = 1 cycles.
- clear_in  input  1  synchronous clear of all state to the post-reset state, level-sensitive.
- locked_out  output  1  expected-value register seeded.
- burst_done_out  output  1  one-cycle pulse at end of each burst.
- burst_ok_out  output  1  result of the last completed burst, held until the next burst_done_out.
- burst_len_out  output  16  length of the last completed burst, held.
- burst_cnt_out  output  16  completed bursts, saturating at 0xFFFF.
- err_cnt_out  output  16  total data mismatches, saturating at 0xFFFF.
- first_err_exp_out  output  32  expected value at the first mismatch.
- first_err_got_out  output  32  received value at the first mismatch.

## Operation
- FSM states: UNLOCKED, IDLE, RUN.
- UNLOCKED: first valid word is the seed, not checked; expected ← data_in + 1; word count ← 1; locked ← 1; go to RUN.
- IDLE: valid word → check, word count ← 1, go to RUN.
- RUN: valid word → check, word count + 1 (saturating at 0xFFFF); valid_in = 0 → burst ends, go to IDLE.
- Check: mismatch when data_in ≠ expected; err_cnt + 1 (saturating); burst marked bad. Expected always resyncs to data_in + 1, matched or not.
  - One corrupted word gives 2 errors.
  - One dropped word gives 1 error.
- First mismatch since reset/clear: latch expected and received into first_err_*. Later mismatches do not overwrite.
- Burst end:
  - burst_ok ← (word count == BURST_LEN) and no mismatch in the burst.
  - burst_len ← word count.
  - burst_cnt + 1 (saturating).
  - Per-burst bad flag cleared.
- All arithmetic is modulo 2^32 on data and saturating on the 16-bit counters.

## Timing
- Reset or clear values:
  - FSM state = UNLOCKED.
  - All outputs 0, including burst_ok_out, which reads 0 until the first burst completes.
  - Expected register = 0.
- All outputs are registered.
- A mismatching word sampled at edge N is reflected in err_cnt_out and first_err_*_out after edge N, i.e. visible in cycle N+1.
- The first valid_in = 0 is sampled at edge M. burst_done_out is high for exactly cycle M+1. burst_ok/len/cnt update at the same edge.
- A new burst may start in cycle M+1 (gap of one idle cycle). It is handled normally, with no lost word.
- clear_in = 1 has priority over valid_in. A word presented in a clear cycle is ignored, and no burst_done_out is produced for the aborted burst.
- Reset asserted mid-burst behaves the same as clear: the next valid word becomes a new seed.
- Wrap case: expected 0xFFFFFFFF followed by received 0x00000000 is a match.

## Structure
- Package data_check_pkg contains:
  - DATA_W = 32 and CNT_W = 16.
  - The FSM state enum {UNLOCKED, IDLE, RUN}.
  - The default BURST_LEN = 8192, shared with the generator.
- Sub-module sat_counter (parameter width; inc and clr inputs; saturates at all-ones) is used for err_cnt, burst_cnt and the word count.

## Test plan
- Reset, then a burst of 8192 words counting 0x00000000..0x00001FFF:
  - locked_out = 1 after the first word.
  - One burst_done_out pulse.
  - burst_ok_out = 1, burst_len_out = 8192, err_cnt_out = 0.
- Second burst continuing 0x00002000..0x00003FFF after a 1-cycle gap:
  - Second done pulse.
  - burst_cnt_out = 2, burst_ok_out = 1.
- Word 0x00000010 replaced by 0xDEADBEEF in an 8192-word burst:
  - err_cnt_out = 2.
  - first_err_exp_out = 0x00000010, first_err_got_out = 0xDEADBEEF.
  - burst_ok_out = 0.
- Seed 0xFFFFFFFE, then 0xFFFFFFFF, 0x00000000, 0x00000001 (BURST_LEN = 4):
  - err_cnt_out = 0, burst_ok_out = 1.
- Burst of 100 correct words, BURST_LEN = 8192:
  - burst_len_out = 100, burst_ok_out = 0, err_cnt_out = 0.
- clear_in asserted at word 50 of a burst, with valid_in held high:
  - No burst_done_out for the aborted burst.
  - All outputs 0 during the clear.
  - The word after clear deasserts becomes the new seed; locked_out = 1 again with no error counted.
